// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier-side producer, the product accumulator and its consumer.
// The master modport is the environment side; the slave modport is the accumulator.
interface product_accumulator_if #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;
  logic [7:0]        count;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, count
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, count
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums BLOCK_LEN unsigned products per block and offers the sum on a valid/ready port.
// Optional macro ACC_SATURATE_EN clamps the running sum at 2^ACC_W-1 instead of wrapping.
module product_accumulator #(
  parameter int unsigned PROD_W    = 8,
  parameter int unsigned ACC_W     = 12,
  parameter int unsigned BLOCK_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  product_accumulator_if.slave  bus
);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  localparam logic [7:0] LastIdx = 8'(BLOCK_LEN - 1);

  state_e           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [7:0]       r_count, w_count_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [ACC_W-1:0] r_out_sum, w_out_sum_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_out_ovf, w_out_ovf_nxt;
  logic             r_live;

  logic             w_in_ready;
  logic             w_accept;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_add;
  logic             w_ovf_add;

  // r_live keeps in_ready low until the first edge after reset release.
  assign w_in_ready = r_live & (r_state == StAccum) & ~clr;
  assign w_accept   = bus.in_valid & w_in_ready;

  assign w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(bus.in_prod);
  assign w_carry   = w_sum[ACC_W];
  assign w_ovf_add = r_ovf | w_carry;

`ifdef ACC_SATURATE_EN
  assign w_acc_add = w_ovf_add ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_add = w_sum[ACC_W-1:0];
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_count_nxt     = r_count;
    w_ovf_nxt       = r_ovf;
    w_out_sum_nxt   = r_out_sum;
    w_out_valid_nxt = r_out_valid;
    w_out_ovf_nxt   = r_out_ovf;

    if (clr) begin
      w_state_nxt     = StAccum;
      w_acc_nxt       = '0;
      w_count_nxt     = '0;
      w_ovf_nxt       = 1'b0;
      w_out_valid_nxt = 1'b0;
    end else begin
      unique case (r_state)
        StAccum: begin
          if (w_accept) begin
            if (r_count == LastIdx) begin
              w_out_sum_nxt   = w_acc_add;
              w_out_ovf_nxt   = w_ovf_add;
              w_out_valid_nxt = 1'b1;
              w_state_nxt     = StHold;
              w_acc_nxt       = '0;
              w_count_nxt     = '0;
              w_ovf_nxt       = 1'b0;
            end else begin
              w_acc_nxt   = w_acc_add;
              w_count_nxt = r_count + 8'd1;
              w_ovf_nxt   = w_ovf_add;
            end
          end
        end
        StHold: begin
          if (r_out_valid && bus.out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = StAccum;
          end
        end
        default: w_state_nxt = StAccum;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StAccum;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_valid <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_live      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_count     <= w_count_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_sum   <= w_out_sum_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
      r_live      <= 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 12-bit instance plus a 10-bit instance fed the
// same stream to exercise wrap (or clamp when ACC_SATURATE_EN is defined).
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_prod = '0;
  logic       out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(8), .ACC_W(12)) bus_a ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(10)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_prod   = in_prod;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_prod   = in_prod;
  assign bus_b.out_ready = out_ready;

  product_accumulator #(.PROD_W(8), .ACC_W(12), .BLOCK_LEN(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus_a.slave)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(10), .BLOCK_LEN(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back accepts of a constant product; returns just after the last accept edge.
  task automatic run_block(input int val, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_prod  = 8'(val);
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int exp_b_sum;
    exp_b_sum = 528;
`ifdef ACC_SATURATE_EN
    exp_b_sum = 1023;
`endif

    // Reset state
    step();
    step();
    rst_n = 1'b1;
    check("rst_in_ready_first_cycle", 32'(bus_a.in_ready), 0);
    step();
    check("rst_in_ready", 32'(bus_a.in_ready), 1);
    check("rst_out_valid", 32'(bus_a.out_valid), 0);
    check("rst_out_sum", 32'(bus_a.out_sum), 0);
    check("rst_out_ovf", 32'(bus_a.out_ovf), 0);
    check("rst_count", 32'(bus_a.count), 0);

    // 16 x 225 back-to-back
    out_ready = 1'b1;
    run_block(225, 8);
    check("t1_count_mid", 32'(bus_a.count), 8);
    run_block(225, 8);
    check("t1_out_valid", 32'(bus_a.out_valid), 1);
    check("t1_out_sum", 32'(bus_a.out_sum), 3600);
    check("t1_out_ovf", 32'(bus_a.out_ovf), 0);
    check("t1_in_ready_hold", 32'(bus_a.in_ready), 0);
    check("t1_count_hold", 32'(bus_a.count), 0);
    check("t5_narrow_sum", 32'(bus_b.out_sum), 32'(exp_b_sum));
    check("t5_narrow_ovf", 32'(bus_b.out_ovf), 1);
    step();
    check("t1_out_valid_drop", 32'(bus_a.out_valid), 0);
    check("t1_in_ready_back", 32'(bus_a.in_ready), 1);

    // Multiplier stream: block i carries i*j for j=0..15
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        in_valid = 1'b1;
        in_prod  = 8'(i * j);
        step();
      end
      in_valid = 1'b0;
      check($sformatf("t2_sum_blk%0d", i), 32'(bus_a.out_sum), 32'(i * 120));
      check($sformatf("t2_ovf_blk%0d", i), 32'(bus_a.out_ovf), 0);
      step();
    end

    // Backpressure with ignored input pulses
    out_ready = 1'b0;
    run_block(10, 16);
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", 32'(bus_a.out_valid), 1);
      check("t3_hold_in_ready", 32'(bus_a.in_ready), 0);
      check("t3_hold_sum", 32'(bus_a.out_sum), 160);
      in_valid = k[0];
      in_prod  = 8'($urandom_range(255));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("t3_release_valid", 32'(bus_a.out_valid), 0);
    check("t3_release_in_ready", 32'(bus_a.in_ready), 1);
    check("t3_release_count", 32'(bus_a.count), 0);
    run_block(1, 16);
    check("t3_next_sum", 32'(bus_a.out_sum), 16);
    step();

    // clr with a coincident in_valid
    run_block(5, 7);
    check("t4_count_before", 32'(bus_a.count), 7);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_prod  = 8'd200;
    #1;
    check("t4_in_ready_clr", 32'(bus_a.in_ready), 0);
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("t4_count_after", 32'(bus_a.count), 0);
    run_block(1, 15);
    check("t4_no_valid_early", 32'(bus_a.out_valid), 0);
    run_block(1, 1);
    check("t4_sum", 32'(bus_a.out_sum), 16);
    step();

    // Async reset mid-block
    run_block(2, 9);
    check("t6_count_mid", 32'(bus_a.count), 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_count_async", 32'(bus_a.count), 0);
    check("t6_sum_async", 32'(bus_a.out_sum), 0);
    check("t6_in_ready_async", 32'(bus_a.in_ready), 0);
    step();
    rst_n = 1'b1;
    step();
    run_block(3, 16);
    check("t6_sum_after_reset", 32'(bus_a.out_sum), 48);
    step();

    // Async reset while holding a result
    out_ready = 1'b0;
    run_block(3, 16);
    check("t6_hold_valid", 32'(bus_a.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_hold_valid_async", 32'(bus_a.out_valid), 0);
    check("t6_hold_sum_async", 32'(bus_a.out_sum), 0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    run_block(4, 16);
    check("t6_final_sum", 32'(bus_a.out_sum), 64);
    check("t6_final_valid", 32'(bus_a.out_valid), 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
